cpu_control_unit: RTL and testbench

Multicycle control unit for the 18-bit CPU.
- Fetches instructions over a req/ack memory handshake and holds the program counter (PC) and instruction register (IR).
- Decodes each instruction and drives the control inputs of the register file, ALU and memory.
- Owns all sequencing; the ALU and the 18-bit adder are purely combinational slaves.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_instr_decoder.sv | 63 ++++++
 rtl/cpu_control_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants, opcodes, ALU codes, state encoding and IR field positions
// for the 18-bit multicycle CPU controller.
package cpu_pkg;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned IMM_W  = 6;

  // IR field least-significant bit positions
  localparam int unsigned OpcLsb = 14;
  localparam int unsigned RdLsb  = 10;
  localparam int unsigned Rs1Lsb = 6;
  localparam int unsigned Rs2Lsb = 2;

  localparam logic [OPC_W-1:0] OpAdd  = 4'd0;
  localparam logic [OPC_W-1:0] OpAddi = 4'd1;
  localparam logic [OPC_W-1:0] OpAnd  = 4'd2;
  localparam logic [OPC_W-1:0] OpAndi = 4'd3;
  localparam logic [OPC_W-1:0] OpNand = 4'd4;
  localparam logic [OPC_W-1:0] OpNor  = 4'd5;
  localparam logic [OPC_W-1:0] OpLd   = 4'd6;
  localparam logic [OPC_W-1:0] OpSt   = 4'd7;
  localparam logic [OPC_W-1:0] OpBeq  = 4'd8;
  localparam logic [OPC_W-1:0] OpJump = 4'd9;
  localparam logic [OPC_W-1:0] OpHalt = 4'd15;

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluAnd  = 2'b01;
  localparam logic [1:0] AluNand = 2'b10;
  localparam logic [1:0] AluNor  = 2'b11;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_e;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] f);
    return {{(DATA_W-IMM_W){f[IMM_W-1]}}, f};
  endfunction

  function automatic logic [ADDR_W-1:0] sext_off(input logic [IMM_W-1:0] f);
    return {{(ADDR_W-IMM_W){f[IMM_W-1]}}, f};
  endfunction

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational opcode decoder: classifies the instruction and selects the
// ALU operation and operand-B source.
module cpu_instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [1:0]       alu_control,
  output logic             alu_bsel,
  output logic             is_ld,
  output logic             is_st,
  output logic             is_br,
  output logic             is_jmp,
  output logic             is_halt,
  output logic             is_illegal,
  output logic             writes_rd
);

  always_comb begin
    alu_control = AluAdd;
    alu_bsel    = 1'b0;
    is_ld       = 1'b0;
    is_st       = 1'b0;
    is_br       = 1'b0;
    is_jmp      = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = 1'b0;
    writes_rd   = 1'b0;
    case (opcode)
      OpAdd:  writes_rd = 1'b1;
      OpAddi: begin
        writes_rd = 1'b1;
        alu_bsel  = 1'b1;
      end
      OpAnd: begin
        writes_rd   = 1'b1;
        alu_control = AluAnd;
      end
      OpAndi: begin
        writes_rd   = 1'b1;
        alu_control = AluAnd;
        alu_bsel    = 1'b1;
      end
      OpNand: begin
        writes_rd   = 1'b1;
        alu_control = AluNand;
      end
      OpNor: begin
        writes_rd   = 1'b1;
        alu_control = AluNor;
      end
      OpLd: begin
        is_ld     = 1'b1;
        writes_rd = 1'b1;
      end
      OpSt:   is_st   = 1'b1;
      OpBeq:  is_br   = 1'b1;
      OpJump: is_jmp  = 1'b1;
      OpHalt: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multicycle controller: owns PC, IR and the fetch/decode/execute/mem/writeback
// sequence, driving register file, ALU and memory handshake controls.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic              C,
  input  logic              R_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mdr_load,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  output logic [REG_AW-1:0] rf_wa,
  output logic              rf_we,
  output logic              rf_wsel,
  output logic [1:0]        alu_control,
  output logic              alu_bsel,
  output logic [DATA_W-1:0] imm,
  input  logic              rf_eq,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                illegal_q, illegal_d;

  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [REG_AW-1:0]   rf_ra1_q, rf_ra1_d;
  logic [REG_AW-1:0]   rf_ra2_q, rf_ra2_d;
  logic [REG_AW-1:0]   rf_wa_q, rf_wa_d;
  logic                rf_we_q, rf_we_d;
  logic                rf_wsel_q, rf_wsel_d;
  logic [1:0]          alu_control_q, alu_control_d;
  logic                alu_bsel_q, alu_bsel_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                halted_q, halted_d;

  logic [1:0]          dec_alu_control;
  logic                dec_alu_bsel, dec_is_ld, dec_is_st, dec_is_br, dec_is_jmp;
  logic                dec_is_halt, dec_is_illegal, dec_writes_rd;
  logic                mem_done;
  logic [REG_AW-1:0]   f_rd, f_rs1, f_rs2;

  // An ack only counts while a request is actually outstanding.
  assign mem_done = mem_req_q & mem_ack;

  // IR only changes on a completed fetch; decoding ir_d lets the registered
  // outputs for the next state be prepared from the incoming instruction.
  assign ir_d  = (state_q == StFetch && mem_done) ? mem_rdata : ir_q;
  assign f_rd  = ir_d[RdLsb +: REG_AW];
  assign f_rs1 = ir_d[Rs1Lsb +: REG_AW];
  assign f_rs2 = ir_d[Rs2Lsb +: REG_AW];

  cpu_instr_decoder u_decoder (
    .opcode      (ir_d[OpcLsb +: OPC_W]),
    .alu_control (dec_alu_control),
    .alu_bsel    (dec_alu_bsel),
    .is_ld       (dec_is_ld),
    .is_st       (dec_is_st),
    .is_br       (dec_is_br),
    .is_jmp      (dec_is_jmp),
    .is_halt     (dec_is_halt),
    .is_illegal  (dec_is_illegal),
    .writes_rd   (dec_writes_rd)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StFetch: begin
        if (mem_done) begin
          pc_d    = pc_q + 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_is_illegal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        if (dec_is_ld || dec_is_st) begin
          state_d = StMem;
        end else if (dec_is_br) begin
          if (rf_eq) pc_d = pc_q + sext_off(ir_q[IMM_W-1:0]);
          state_d = StFetch;
        end else if (dec_is_jmp) begin
          pc_d    = ir_q[ADDR_W-1:0];
          state_d = StFetch;
        end else if (dec_is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StWriteback;
        end
      end
      StMem: begin
        if (mem_done) state_d = dec_is_st ? StFetch : StWriteback;
      end
      StWriteback: state_d = StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StHalt;
    endcase
  end

  // Output values for the state being entered; registered below.
  always_comb begin
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    rf_ra1_d      = '0;
    rf_ra2_d      = '0;
    rf_wa_d       = '0;
    rf_we_d       = 1'b0;
    rf_wsel_d     = 1'b0;
    alu_control_d = AluAdd;
    alu_bsel_d    = 1'b0;
    imm_d         = '0;
    halted_d      = 1'b0;
    unique case (state_d)
      StFetch: begin
        mem_req_d  = 1'b1;
        mem_addr_d = pc_d;
      end
      StDecode, StExecute: begin
        // Read ports stay valid through EXECUTE so rf_eq and ALU operands settle.
        if (dec_is_br) begin
          rf_ra1_d = f_rd;
          rf_ra2_d = f_rs1;
        end else if (dec_is_st) begin
          rf_ra2_d = f_rd;
        end else if (dec_writes_rd && !dec_is_ld) begin
          rf_ra1_d = f_rs1;
          if (!dec_alu_bsel) rf_ra2_d = f_rs2;
        end
        if (state_d == StExecute) begin
          alu_control_d = dec_alu_control;
          alu_bsel_d    = dec_alu_bsel;
          imm_d         = sext_imm(ir_d[IMM_W-1:0]);
        end
      end
      StMem: begin
        mem_req_d  = 1'b1;
        mem_we_d   = dec_is_st;
        mem_addr_d = ir_d[ADDR_W-1:0];
        // Store data comes from read port 2 while the write is pending.
        if (dec_is_st) rf_ra2_d = f_rd;
      end
      StWriteback: begin
        rf_we_d   = 1'b1;
        rf_wa_d   = f_rd;
        rf_wsel_d = dec_is_ld;
      end
      StHalt:  halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge C or negedge R_n) begin
    if (!R_n) begin
      state_q       <= StFetch;
      pc_q          <= '0;
      ir_q          <= '0;
      illegal_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      rf_ra1_q      <= '0;
      rf_ra2_q      <= '0;
      rf_wa_q       <= '0;
      rf_we_q       <= 1'b0;
      rf_wsel_q     <= 1'b0;
      alu_control_q <= AluAdd;
      alu_bsel_q    <= 1'b0;
      imm_q         <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      illegal_q     <= illegal_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      rf_ra1_q      <= rf_ra1_d;
      rf_ra2_q      <= rf_ra2_d;
      rf_wa_q       <= rf_wa_d;
      rf_we_q       <= rf_we_d;
      rf_wsel_q     <= rf_wsel_d;
      alu_control_q <= alu_control_d;
      alu_bsel_q    <= alu_bsel_d;
      imm_q         <= imm_d;
      halted_q      <= halted_d;
    end
  end

  // Datapath latches load data on the ack edge itself, so this strobe is unregistered.
  assign mdr_load    = (state_q == StMem) && mem_done && !mem_we_q;

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign rf_ra1      = rf_ra1_q;
  assign rf_ra2      = rf_ra2_q;
  assign rf_wa       = rf_wa_q;
  assign rf_we       = rf_we_q;
  assign rf_wsel     = rf_wsel_q;
  assign alu_control = alu_control_q;
  assign alu_bsel    = alu_bsel_q;
  assign imm         = imm_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a table of single-instruction vectors
// followed by hand sequences for wait states, illegal opcode, halt and reset.
module tb_cpu_control_unit;

  logic        C, R_n;
  logic        mem_req, mem_we, mem_ack, mdr_load;
  logic [9:0]  mem_addr, pc;
  logic [17:0] mem_rdata, imm;
  logic [3:0]  rf_ra1, rf_ra2, rf_wa;
  logic        rf_we, rf_wsel, alu_bsel, rf_eq, halted, illegal;
  logic [1:0]  alu_control;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_fetch;

  typedef struct {
    logic [17:0] instr;
    logic        eq;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [1:0]  alu;
    logic        bsel;
    logic [17:0] imm;
    logic        wr;
    logic [3:0]  wa;
    logic        wsel;
    logic [9:0]  maddr;
    logic [9:0]  npc;
    int          cycles;
  } vec_t;

  vec_t vecs[14];

  cpu_control_unit dut (
    .C           (C),
    .R_n         (R_n),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mdr_load    (mdr_load),
    .rf_ra1      (rf_ra1),
    .rf_ra2      (rf_ra2),
    .rf_wa       (rf_wa),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .alu_control (alu_control),
    .alu_bsel    (alu_bsel),
    .imm         (imm),
    .rf_eq       (rf_eq),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && mem_req !== 1'b1; k++) @(negedge C);
    check("wait_req", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    logic got_wr;
    logic [3:0] got_wa;
    logic got_wsel;
    logic [9:0] pc_inc;
    got_wr = 1'b0;
    got_wa = '0;
    got_wsel = 1'b0;
    pc_inc = exp_fetch + 10'd1;
    wait_req();
    check($sformatf("v%0d_fetch_addr", idx), mem_addr, exp_fetch);
    check($sformatf("v%0d_fetch_we", idx), mem_we, 0);
    mem_ack = 1'b1;
    mem_rdata = v.instr;
    @(negedge C);
    mem_ack = 1'b0;
    mem_rdata = '0;
    check($sformatf("v%0d_dec_ra1", idx), rf_ra1, v.ra1);
    check($sformatf("v%0d_dec_ra2", idx), rf_ra2, v.ra2);
    check($sformatf("v%0d_dec_req", idx), mem_req, 0);
    check($sformatf("v%0d_dec_pc", idx), pc, pc_inc);
    rf_eq = v.eq;
    @(negedge C);
    check($sformatf("v%0d_ex_alu", idx), alu_control, v.alu);
    check($sformatf("v%0d_ex_bsel", idx), alu_bsel, v.bsel);
    check($sformatf("v%0d_ex_imm", idx), imm, v.imm);
    check($sformatf("v%0d_ex_we", idx), rf_we, 0);
    n = 2;
    for (int k = 0; k < 10; k++) begin
      @(negedge C);
      mem_ack = 1'b0;
      n++;
      if (rf_we) begin
        got_wr = 1'b1;
        got_wa = rf_wa;
        got_wsel = rf_wsel;
      end
      if (mem_req && mem_we) begin
        check($sformatf("v%0d_st_addr", idx), mem_addr, v.maddr);
        mem_ack = 1'b1;
      end else if (mem_req) begin
        break;
      end
    end
    rf_eq = 1'b0;
    check($sformatf("v%0d_cycles", idx), n, v.cycles);
    check($sformatf("v%0d_wr", idx), got_wr, v.wr);
    check($sformatf("v%0d_wa", idx), got_wa, v.wa);
    check($sformatf("v%0d_wsel", idx), got_wsel, v.wsel);
    check($sformatf("v%0d_npc", idx), pc, v.npc);
    exp_fetch = v.npc;
  endtask

  initial begin
    int bad;
    //          instr      eq    ra1    ra2    alu   bsel  imm         wr    wa     wsel  maddr    npc      cyc
    vecs[0]  = '{18'h00C48, 1'b0, 4'd1,  4'd2,  2'd0, 1'b0, 18'h00008, 1'b1, 4'd3,  1'b0, 10'h000, 10'h001, 4};
    vecs[1]  = '{18'h049FF, 1'b0, 4'd7,  4'd0,  2'd0, 1'b1, 18'h3FFFF, 1'b1, 4'd2,  1'b0, 10'h000, 10'h002, 4};
    vecs[2]  = '{18'h0BFB4, 1'b0, 4'd14, 4'd13, 2'd1, 1'b0, 18'h3FFF4, 1'b1, 4'd15, 1'b0, 10'h000, 10'h003, 4};
    vecs[3]  = '{18'h0C005, 1'b0, 4'd0,  4'd0,  2'd1, 1'b1, 18'h00005, 1'b1, 4'd0,  1'b0, 10'h000, 10'h004, 4};
    vecs[4]  = '{18'h1048C, 1'b0, 4'd2,  4'd3,  2'd2, 1'b0, 18'h0000C, 1'b1, 4'd1,  1'b0, 10'h000, 10'h005, 4};
    vecs[5]  = '{18'h15158, 1'b0, 4'd5,  4'd6,  2'd3, 1'b0, 18'h00018, 1'b1, 4'd4,  1'b0, 10'h000, 10'h006, 4};
    vecs[6]  = '{18'h1E523, 1'b0, 4'd0,  4'd9,  2'd0, 1'b0, 18'h3FFE3, 1'b0, 4'd0,  1'b0, 10'h123, 10'h007, 4};
    vecs[7]  = '{18'h20483, 1'b0, 4'd1,  4'd2,  2'd0, 1'b0, 18'h00003, 1'b0, 4'd0,  1'b0, 10'h000, 10'h008, 3};
    vecs[8]  = '{18'h20483, 1'b1, 4'd1,  4'd2,  2'd0, 1'b0, 18'h00003, 1'b0, 4'd0,  1'b0, 10'h000, 10'h00C, 3};
    vecs[9]  = '{18'h243FE, 1'b0, 4'd0,  4'd0,  2'd0, 1'b0, 18'h3FFFE, 1'b0, 4'd0,  1'b0, 10'h000, 10'h3FE, 3};
    vecs[10] = '{18'h2003E, 1'b1, 4'd0,  4'd0,  2'd0, 1'b0, 18'h3FFFE, 1'b0, 4'd0,  1'b0, 10'h000, 10'h3FD, 3};
    vecs[11] = '{18'h243FE, 1'b0, 4'd0,  4'd0,  2'd0, 1'b0, 18'h3FFFE, 1'b0, 4'd0,  1'b0, 10'h000, 10'h3FE, 3};
    vecs[12] = '{18'h2003E, 1'b0, 4'd0,  4'd0,  2'd0, 1'b0, 18'h3FFFE, 1'b0, 4'd0,  1'b0, 10'h000, 10'h3FF, 3};
    vecs[13] = '{18'h24000, 1'b0, 4'd0,  4'd0,  2'd0, 1'b0, 18'h00000, 1'b0, 4'd0,  1'b0, 10'h000, 10'h000, 3};

    R_n = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    rf_eq = 1'b0;
    exp_fetch = '0;
    #2 R_n = 1'b0;
    #10;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", rf_we, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_mdr", mdr_load, 0);

    // Release with a stray ack (HALT word) while no request is outstanding.
    @(negedge C);
    R_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 18'h3C000;
    @(negedge C);
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("first_req", mem_req, 1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // LD R5,0x3FF: one wait state on fetch, two on the data access.
    wait_req();
    check("ld_fetch_addr", mem_addr, 0);
    @(negedge C);
    check("ld_fetch_hold", mem_req, 1);
    mem_ack = 1'b1;
    mem_rdata = 18'h197FF;
    @(negedge C);
    mem_ack = 1'b0;
    check("ld_dec_pc", pc, 1);
    @(negedge C);
    check("ld_ex_alu", alu_control, 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge C);
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h3FF) bad++;
      if (k < 2 && mdr_load !== 1'b0) bad++;
    end
    check("ld_mem_phase", bad, 0);
    mem_ack = 1'b1;
    #1;
    check("ld_mdr_load", mdr_load, 1);
    @(negedge C);
    mem_ack = 1'b0;
    check("ld_wb_we", rf_we, 1);
    check("ld_wb_wa", rf_wa, 5);
    check("ld_wb_wsel", rf_wsel, 1);
    check("ld_wb_req", mem_req, 0);
    @(negedge C);
    check("ld_after_we", rf_we, 0);
    check("ld_next_fetch", {mem_req, mem_addr}, {1'b1, 10'h001});

    // Illegal opcode 0xC halts right after DECODE.
    mem_ack = 1'b1;
    mem_rdata = 18'h30000;
    @(negedge C);
    mem_ack = 1'b0;
    check("ill_dec_halted", halted, 0);
    @(negedge C);
    check("ill_halted", halted, 1);
    check("ill_illegal", illegal, 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge C);
      if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    check("ill_quiet", bad, 0);
    check("ill_pc", pc, 2);

    // Reset in MEM with a store pending.
    R_n = 1'b0;
    #1;
    check("rst2_halted", halted, 0);
    check("rst2_illegal", illegal, 0);
    @(negedge C);
    R_n = 1'b1;
    @(negedge C);
    check("rst2_fetch", {mem_req, mem_addr}, {1'b1, 10'h000});
    mem_ack = 1'b1;
    mem_rdata = 18'h1C455;
    @(negedge C);
    mem_ack = 1'b0;
    @(negedge C);
    @(negedge C);
    check("st_mem", {mem_req, mem_we, mem_addr}, {2'b11, 10'h055});
    #3 R_n = 1'b0;
    #1;
    check("st_rst_req", mem_req, 0);
    check("st_rst_we", mem_we, 0);
    check("st_rst_pc", pc, 0);
    check("st_rst_rfwe", rf_we, 0);
    @(negedge C);
    R_n = 1'b1;
    @(negedge C);
    check("st_restart", {mem_req, mem_addr, rf_we}, {1'b1, 10'h000, 1'b0});

    // HALT opcode: three cycles to halt, not flagged illegal.
    mem_ack = 1'b1;
    mem_rdata = 18'h3C000;
    @(negedge C);
    mem_ack = 1'b0;
    @(negedge C);
    check("halt_ex", halted, 0);
    @(negedge C);
    check("halt_halted", halted, 1);
    check("halt_illegal", illegal, 0);
    check("halt_req", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
